// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//   Sequential stimulus/checker for a small combinational unit-under-test.
//   Sweeps every input vector 0..2^N_IN-1 onto o_stim. Each vector is held
//   for SETTLE cycles, then i_resp is compared against the expected table EXP.
//   The result is reported as pass/fail, a mismatch count and the lowest
//   failing vector.
//
//   Optional feature macro: TT_STOP_ON_FAIL_EN
//     defined   -> the first mismatching vector ends the sweep immediately
//     undefined -> all vectors are always swept (default)
//
// Parameters
//   N_IN    UUT input count (stim width)
//   N_OUT   UUT output count (resp width)
//   SETTLE  drive cycles per vector before sampling (1..15)
//   EXP     expected table, EXP[j*2^N_IN+v] = expected resp[j] for vector v
//
// Ports
//   i_clk              rising-edge clock
//   i_reset            synchronous active-high reset
//   i_start            sweep request, honoured in IDLE only
//   i_resp             UUT outputs
//   o_stim             UUT inputs, MSB is x
//   o_busy             high while driving/sampling vectors
//   o_done             one-cycle pulse when a sweep ends
//   o_pass             last sweep had no mismatches (held until next start)
//   o_err_count        mismatching vectors in current/last sweep
//   o_first_fail_vec   lowest mismatching vector, 0 if none
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 1,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXP = 8'b0111_0010
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [N_OUT-1:0]  i_resp,
    output logic [N_IN-1:0]   o_stim,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [N_IN:0]     o_err_count,
    output logic [N_IN-1:0]   o_first_fail_vec
);

    localparam int             NV          = 2**N_IN;
    localparam int             VW          = N_IN + 1;
    localparam logic [N_IN:0]  VEC_ZERO    = VW'(0);
    localparam logic [N_IN:0]  VEC_ONE     = VW'(1);
    localparam logic [N_IN:0]  LAST_VEC    = VW'(NV - 1);
    localparam logic [N_IN:0]  MAX_ERR     = VW'(NV);
    localparam logic [3:0]     SETTLE_INIT = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [N_IN:0]      r_vec;
    logic [3:0]         r_settle;
    logic [N_IN-1:0]    r_stim;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [N_IN:0]      r_err;
    logic [N_IN-1:0]    r_ffv;

    logic [N_IN:0]      w_vec_nx;
    logic [3:0]         w_settle_nx;
    logic               w_busy_nx;
    logic               w_done_nx;
    logic               w_pass_nx;
    logic [N_IN:0]      w_err_nx;
    logic [N_IN-1:0]    w_ffv_nx;
    logic [N_OUT-1:0]   w_exp_row;
    logic               w_mismatch;
    logic               w_last_vec;

    // Expected response for the current vector: one table row per output bit.
    for (genvar j = 0; j < N_OUT; j++) begin : g_exp_row
        localparam logic [NV-1:0] ROW = EXP[j*NV +: NV];
        assign w_exp_row[j] = ROW[r_vec[N_IN-1:0]];
    end

    // Case-inequality so that X/Z on the response is reported as a mismatch.
    assign w_mismatch = (i_resp !== w_exp_row);
    assign w_last_vec = (r_vec == LAST_VEC);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next_state = S_DRIVE;
                else         w_next_state = S_IDLE;
            end
            S_DRIVE: begin
                if (r_settle == 4'd1) w_next_state = S_SAMPLE;
                else                  w_next_state = S_DRIVE;
            end
            S_SAMPLE: begin
`ifdef TT_STOP_ON_FAIL_EN
                if (w_mismatch || w_last_vec) w_next_state = S_FINISH;
                else                          w_next_state = S_DRIVE;
`else
                if (w_last_vec) w_next_state = S_FINISH;
                else            w_next_state = S_DRIVE;
`endif
            end
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Next values of the datapath and output registers.
    always_comb begin
        w_vec_nx    = r_vec;
        w_settle_nx = r_settle;
        w_err_nx    = r_err;
        w_ffv_nx    = r_ffv;
        w_pass_nx   = r_pass;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_vec_nx    = VEC_ZERO;
                    w_settle_nx = SETTLE_INIT;
                    w_err_nx    = VEC_ZERO;
                    w_ffv_nx    = {N_IN{1'b0}};
                    w_pass_nx   = 1'b0;
                end else begin
                    w_vec_nx    = r_vec;
                end
            end
            S_DRIVE: begin
                w_settle_nx = r_settle - 4'd1;
            end
            S_SAMPLE: begin
                if (w_mismatch) begin
                    // Only the first mismatch of a sweep records its vector.
                    if (r_err == VEC_ZERO) w_ffv_nx = r_vec[N_IN-1:0];
                    else                   w_ffv_nx = r_ffv;
                    if (r_err != MAX_ERR)  w_err_nx = r_err + VEC_ONE;
                    else                   w_err_nx = r_err;
                end else begin
                    w_err_nx = r_err;
                end
                if (w_next_state == S_DRIVE) begin
                    w_vec_nx    = r_vec + VEC_ONE;
                    w_settle_nx = SETTLE_INIT;
                end else begin
                    w_pass_nx   = (w_err_nx == VEC_ZERO);
                end
            end
            S_FINISH: begin
                w_vec_nx = r_vec;
            end
            default: begin
                w_vec_nx = r_vec;
            end
        endcase
        w_busy_nx = (w_next_state == S_DRIVE) || (w_next_state == S_SAMPLE);
        w_done_nx = (w_next_state == S_FINISH);
    end

    // Datapath and output registers; stim follows the vector counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vec    <= VEC_ZERO;
            r_settle <= 4'd0;
            r_stim   <= {N_IN{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= VEC_ZERO;
            r_ffv    <= {N_IN{1'b0}};
        end else begin
            r_vec    <= w_vec_nx;
            r_settle <= w_settle_nx;
            r_stim   <= w_vec_nx[N_IN-1:0];
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
            r_pass   <= w_pass_nx;
            r_err    <= w_err_nx;
            r_ffv    <= w_ffv_nx;
        end
    end

    assign o_stim           = r_stim;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_err_count      = r_err;
    assign o_first_fail_vec = r_ffv;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// Directed testbench for truth_table_sweeper (default parameters).
// The UUT model is the gate pair resp[0] = ~x&y, resp[1] = ~x|~y with
// selectable faults. Expected results are hand-computed per scenario.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] resp;
    logic [1:0] stim;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [1:0] first_fail_vec;

    int fault_mode = 0;
    int n_cmp = 0;
    int n_bad = 0;

    truth_table_sweeper dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_start          (start),
        .i_resp           (resp),
        .o_stim           (stim),
        .o_busy           (busy),
        .o_done           (done),
        .o_pass           (pass),
        .o_err_count      (err_count),
        .o_first_fail_vec (first_fail_vec)
    );

    always #5 clk = ~clk;

    // UUT model: 0 good, 1 resp[1] stuck at 0, 2 resp[0] inverted for vector 2.
    always_comb begin
        resp[0] = ~stim[1] & stim[0];
        resp[1] = ~stim[1] | ~stim[0];
        if (fault_mode == 1) resp[1] = 1'b0;
        else if (fault_mode == 2 && stim == 2'd2) resp[0] = ~(~stim[1] & stim[0]);
    end

    // Pulse start, then follow the sweep until done (bounded). cyc is the
    // index of the cycle after the accepting edge in which done is seen.
    task automatic run_sweep(output int cyc, output int stim_bad, output int busy_bad,
                             output int max_stim, output logic busy_at_done,
                             output logic done_after);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; stim_bad = 0; busy_bad = 0; max_stim = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_bad++;
            if (int'(stim) != (cyc - 1) / 2) stim_bad++;
            if (int'(stim) > max_stim) max_stim = int'(stim);
            @(posedge clk); #1;
            cyc++;
        end
        busy_at_done = busy;
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if (stim !== 2'd0) begin n_bad++; $display("FAIL reset_stim got %0d want 0", stim); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass got %b want 0", pass); end
        n_cmp++; if (err_count !== 3'd0) begin n_bad++; $display("FAIL reset_err got %0d want 0", err_count); end
        n_cmp++; if (first_fail_vec !== 2'd0) begin n_bad++; $display("FAIL reset_ffv got %0d want 0", first_fail_vec); end
    endtask

    task automatic test_nominal();
        int cyc, sb, bb, ms; logic bd, da;
        fault_mode = 0;
        run_sweep(cyc, sb, bb, ms, bd, da);
        n_cmp++; if (cyc != 9) begin n_bad++; $display("FAIL nom_latency got %0d want 9", cyc); end
        n_cmp++; if (sb != 0) begin n_bad++; $display("FAIL nom_stim_seq got %0d bad cycles want 0", sb); end
        n_cmp++; if (bb != 0) begin n_bad++; $display("FAIL nom_busy got %0d low cycles want 0", bb); end
        n_cmp++; if (bd !== 1'b0) begin n_bad++; $display("FAIL nom_busy_at_done got %b want 0", bd); end
        n_cmp++; if (da !== 1'b0) begin n_bad++; $display("FAIL nom_done_pulse got %b want 0", da); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL nom_pass got %b want 1", pass); end
        n_cmp++; if (err_count !== 3'd0) begin n_bad++; $display("FAIL nom_err got %0d want 0", err_count); end
        n_cmp++; if (first_fail_vec !== 2'd0) begin n_bad++; $display("FAIL nom_ffv got %0d want 0", first_fail_vec); end
        n_cmp++; if (stim !== 2'd3) begin n_bad++; $display("FAIL nom_stim_hold got %0d want 3", stim); end
    endtask

    task automatic test_stuck_resp1();
        int cyc, sb, bb, ms; logic bd, da;
        fault_mode = 1;
        run_sweep(cyc, sb, bb, ms, bd, da);
        fault_mode = 0;
`ifdef TT_STOP_ON_FAIL_EN
        n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL stuck_latency got %0d want 3", cyc); end
        n_cmp++; if (err_count !== 3'd1) begin n_bad++; $display("FAIL stuck_err got %0d want 1", err_count); end
        n_cmp++; if (ms != 0) begin n_bad++; $display("FAIL stuck_max_stim got %0d want 0", ms); end
`else
        n_cmp++; if (cyc != 9) begin n_bad++; $display("FAIL stuck_latency got %0d want 9", cyc); end
        n_cmp++; if (err_count !== 3'd3) begin n_bad++; $display("FAIL stuck_err got %0d want 3", err_count); end
        n_cmp++; if (ms != 3) begin n_bad++; $display("FAIL stuck_max_stim got %0d want 3", ms); end
`endif
        n_cmp++; if (first_fail_vec !== 2'd0) begin n_bad++; $display("FAIL stuck_ffv got %0d want 0", first_fail_vec); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL stuck_pass got %b want 0", pass); end
        n_cmp++; if (sb != 0) begin n_bad++; $display("FAIL stuck_stim_seq got %0d bad cycles want 0", sb); end
    endtask

    task automatic test_single_vec_fault();
        int cyc, sb, bb, ms; logic bd, da;
        fault_mode = 2;
        run_sweep(cyc, sb, bb, ms, bd, da);
        fault_mode = 0;
`ifdef TT_STOP_ON_FAIL_EN
        n_cmp++; if (cyc != 7) begin n_bad++; $display("FAIL vec2_latency got %0d want 7", cyc); end
`else
        n_cmp++; if (cyc != 9) begin n_bad++; $display("FAIL vec2_latency got %0d want 9", cyc); end
`endif
        n_cmp++; if (err_count !== 3'd1) begin n_bad++; $display("FAIL vec2_err got %0d want 1", err_count); end
        n_cmp++; if (first_fail_vec !== 2'd2) begin n_bad++; $display("FAIL vec2_ffv got %0d want 2", first_fail_vec); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL vec2_pass got %b want 0", pass); end
    endtask

    task automatic test_back_to_back();
        int cyc, sb, bb, ms; logic bd, da;
        // First sweep with a fault, start re-pulsed in cycle 3 must be ignored.
        fault_mode = 2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            start = (cyc == 3);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        fault_mode = 0;
`ifdef TT_STOP_ON_FAIL_EN
        n_cmp++; if (cyc != 7) begin n_bad++; $display("FAIL b2b_latency got %0d want 7", cyc); end
`else
        n_cmp++; if (cyc != 9) begin n_bad++; $display("FAIL b2b_latency got %0d want 9", cyc); end
`endif
        n_cmp++; if (err_count !== 3'd1) begin n_bad++; $display("FAIL b2b_first_err got %0d want 1", err_count); end
        @(posedge clk); #1;
        // Fresh sweep clears the previous error state.
        run_sweep(cyc, sb, bb, ms, bd, da);
        n_cmp++; if (cyc != 9) begin n_bad++; $display("FAIL b2b_second_latency got %0d want 9", cyc); end
        n_cmp++; if (err_count !== 3'd0) begin n_bad++; $display("FAIL b2b_err_cleared got %0d want 0", err_count); end
        n_cmp++; if (first_fail_vec !== 2'd0) begin n_bad++; $display("FAIL b2b_ffv_cleared got %0d want 0", first_fail_vec); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL b2b_pass got %b want 1", pass); end
    endtask

    task automatic test_mid_reset();
        int cyc, sb, bb, ms, dones; logic bd, da;
        fault_mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 5; k++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        fault_mode = 0;
        n_cmp++; if (stim !== 2'd0) begin n_bad++; $display("FAIL mrst_stim got %0d want 0", stim); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy got %b want 0", busy); end
        n_cmp++; if (err_count !== 3'd0) begin n_bad++; $display("FAIL mrst_err got %0d want 0", err_count); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL mrst_pass got %b want 0", pass); end
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) dones++;
            @(posedge clk); #1;
        end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL mrst_idle got %0d active cycles want 0", dones); end
        run_sweep(cyc, sb, bb, ms, bd, da);
        n_cmp++; if (cyc != 9) begin n_bad++; $display("FAIL mrst_resweep_latency got %0d want 9", cyc); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL mrst_resweep_pass got %b want 1", pass); end
    endtask

`ifdef TT_STOP_ON_FAIL_EN
    task automatic test_stop_on_fail();
        int cyc, sb, bb, ms; logic bd, da;
        fault_mode = 1;
        run_sweep(cyc, sb, bb, ms, bd, da);
        fault_mode = 0;
        n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL sof_latency got %0d want 3", cyc); end
        n_cmp++; if (err_count !== 3'd1) begin n_bad++; $display("FAIL sof_err got %0d want 1", err_count); end
        n_cmp++; if (first_fail_vec !== 2'd0) begin n_bad++; $display("FAIL sof_ffv got %0d want 0", first_fail_vec); end
        n_cmp++; if (ms != 0) begin n_bad++; $display("FAIL sof_max_stim got %0d want 0", ms); end
        n_cmp++; if (stim !== 2'd0) begin n_bad++; $display("FAIL sof_stim_hold got %0d want 0", stim); end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_stuck_resp1();
        test_single_vec_fault();
        test_back_to_back();
        test_mid_reset();
`ifdef TT_STOP_ON_FAIL_EN
        test_stop_on_fail();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
